// File: rtl/data_buffer.sv
// data_buffer: shared 64x8 circular FIFO between the AHB and USB sides.
// Sticky overflow/underflow tracking is built only with DATA_BUFFER_ERR_FLAGS_EN.
module data_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       get_rx_data,
  output logic [7:0] rx_data,
  input  logic       store_rx_packet_data,
  input  logic [7:0] rx_packet_data,
  input  logic       get_tx_packet_data,
  output logic [7:0] tx_packet_data,
  output logic [6:0] buffer_occupancy,
  output logic       buffer_overflow,
  output logic       buffer_underflow
);
  logic [7:0] r_mem [64];
  logic [5:0] r_wr_ptr, r_rd_ptr;
  logic [6:0] r_occ;
  logic       w_push, w_pop_req, w_empty, w_full, w_pop, w_wr;
  logic [7:0] w_wdata, w_head;
  assign w_push    = store_tx_data | store_rx_packet_data;
  assign w_pop_req = get_rx_data | get_tx_packet_data;
  assign w_empty   = r_occ == 7'd0;
  assign w_full    = r_occ == 7'd64;
  assign w_pop     = w_pop_req & ~w_empty;
  // a push into a full buffer is only taken when a pop frees the slot in the same cycle
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_wdata   = store_tx_data ? tx_data : rx_packet_data;
  assign w_head    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign rx_data          = w_head;
  assign tx_packet_data   = w_head;
  assign buffer_occupancy = r_occ;
  always_ff @(posedge clk)
    if (!clear && w_wr) r_mem[r_wr_ptr] <= w_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 6'd1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 6'd1;
      if (w_wr != w_pop) r_occ <= w_wr ? r_occ + 7'd1 : r_occ - 7'd1;
    end
`ifdef DATA_BUFFER_ERR_FLAGS_EN
  logic r_ovf, r_unf;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if ((store_tx_data & store_rx_packet_data) | (w_push & ~w_wr)) r_ovf <= 1'b1;
      if (w_pop_req & w_empty) r_unf <= 1'b1;
    end
  assign buffer_overflow  = r_ovf;
  assign buffer_underflow = r_unf;
`else
  assign buffer_overflow  = 1'b0;
  assign buffer_underflow = 1'b0;
`endif
endmodule
